// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

    // Operation encoding as issued by the decode stage.
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    // Operand width of this CPU.
    localparam int MD_DATA_WIDTH = 32;

    // Edges from the accepting start edge to the edge that raises done.
    localparam int MD_LATENCY = 33;

    // True for the two-operand signed operations.
    function automatic logic md_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // True for the two divide operations.
    function automatic logic md_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Final result stage: restores signs on the magnitude result and applies the
// divide-by-zero and signed-overflow overrides. Purely combinational.
module muldiv_sign_adjust
    import mips_muldiv_pkg::*;
#(
    parameter int W = MD_DATA_WIDTH
) (
    input  logic [2*W-1:0] raw_i,       // product, or {remainder, quotient}
    input  muldiv_op_t     op_i,
    input  logic           neg_a_i,     // operand a was negative (signed ops only)
    input  logic           neg_b_i,     // operand b was negative (signed ops only)
    input  logic           div_zero_i,  // divide with a zero divisor
    input  logic           div_ovf_i,   // most-negative / -1 signed divide
    input  logic [W-1:0]   dividend_i,  // raw operand a, reported as HI on divide by zero
    output logic [2*W-1:0] result_o     // {HI, LO}
);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] quot;
    logic [W-1:0] rem;

    // Sign restoration and special-case selection.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can hold a stale value and infer a latch.
        quot     = raw_i[W-1:0];
        rem      = raw_i[2*W-1:W];
        result_o = raw_i;
        if (!md_is_div(op_i)) begin
            if (neg_a_i ^ neg_b_i) begin
                result_o = -raw_i;
            end
        end else begin
            if (neg_a_i ^ neg_b_i) begin
                quot = -quot;
            end
            if (neg_a_i) begin
                rem = -rem;
            end
            if (div_zero_i) begin
                result_o = {dividend_i, {W{1'b1}}};
            end else if (div_ovf_i) begin
                result_o = {{W{1'b0}}, MOST_NEG};
            end else begin
                result_o = {rem, quot};
            end
        end
    end

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register write port.
// One shift-add or restoring subtract-shift step per clock on operand
// magnitudes; signs and special cases are resolved on the final edge, giving
// a fixed latency of DATA_WIDTH+1 edges for every operation.
module hi_lo_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  muldiv_op_t            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  HI_LO_write_enable,
    output logic [DATA_WIDTH-1:0] HI_write_data,
    output logic [DATA_WIDTH-1:0] LO_write_data
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W + 1);
    // The last iteration count; the edge after it finalises the result.
    localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(MD_LATENCY - 1);
    localparam logic [W-1:0]     MOST_NEG   = {1'b1, {(W-1){1'b0}}};

    // Sequencer and datapath state.
    muldiv_state_t    state_q;
    logic [CNT_W-1:0] count_q;
    muldiv_op_t       op_q;
    logic [2*W-1:0]   acc_q;      // mul: {partial hi, multiplier/low bits}; div: {remainder, quotient}
    logic [W-1:0]     opnd_q;     // mul: |multiplicand|; div: |divisor|
    logic [W-1:0]     raw_a_q;    // raw dividend for the divide-by-zero HI value
    logic             neg_a_q;
    logic             neg_b_q;
    logic             div_zero_q;
    logic             div_ovf_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;

    // Issue-time decode.
    logic           start_signed;
    logic           start_div;
    logic           start_neg_a;
    logic           start_neg_b;
    logic [W-1:0]   start_mag_a;
    logic [W-1:0]   start_mag_b;
    logic [2*W-1:0] acc_init;
    logic [W-1:0]   opnd_init;
    logic           start_div_zero;
    logic           start_div_ovf;

    // One iteration step.
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_fits;
    logic [2*W-1:0] acc_step;

    // Final {HI, LO}.
    logic [2*W-1:0] result;

    // Operand magnitudes, sign flags and special-case flags for a new issue.
    always_comb begin
        start_signed   = md_is_signed(op);
        start_div      = md_is_div(op);
        start_neg_a    = start_signed & operand_a[W-1];
        start_neg_b    = start_signed & operand_b[W-1];
        start_mag_a    = start_neg_a ? -operand_a : operand_a;
        start_mag_b    = start_neg_b ? -operand_b : operand_b;
        acc_init       = start_div ? {{W{1'b0}}, start_mag_a} : {{W{1'b0}}, start_mag_b};
        opnd_init      = start_div ? start_mag_b : start_mag_a;
        start_div_zero = start_div && (operand_b == '0);
        start_div_ovf  = (op == MD_DIV) && (operand_a == MOST_NEG) && (operand_b == '1);
    end

    // Next accumulator value for one shift-add or restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_fits  = ~div_diff[W];
        if (!md_is_div(op_q)) begin
            acc_step = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        end else begin
            acc_step = {(div_fits ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_fits};
        end
    end

    muldiv_sign_adjust #(
        .W (W)
    ) u_sign_adjust (
        .raw_i      (acc_q),
        .op_i       (op_q),
        .neg_a_i    (neg_a_q),
        .neg_b_i    (neg_b_q),
        .div_zero_i (div_zero_q),
        .div_ovf_i  (div_ovf_q),
        .dividend_i (raw_a_q),
        .result_o   (result)
    );

    // Sequencer: issue, iterate, finalise; abort and reset abandon the op silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MD_IDLE;
            count_q    <= '0;
            op_q       <= MD_MULT;
            acc_q      <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            case (state_q)
                MD_RUN: begin
                    if (abort) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else if (count_q == LAST_STEP) begin
                        state_q <= MD_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= result[2*W-1:W];
                        lo_q    <= result[W-1:0];
                    end else begin
                        acc_q   <= acc_step;
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new op; abort takes priority over start.
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q    <= MD_RUN;
                        busy_q     <= 1'b1;
                        count_q    <= '0;
                        op_q       <= op;
                        acc_q      <= acc_init;
                        opnd_q     <= opnd_init;
                        raw_a_q    <= operand_a;
                        neg_a_q    <= start_neg_a;
                        neg_b_q    <= start_neg_b;
                        div_zero_q <= start_div_zero;
                        div_ovf_q  <= start_div_ovf;
                    end else begin
                        state_q <= MD_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign HI_LO_write_enable = done_q;
    assign HI_write_data      = hi_q;
    assign LO_write_data      = lo_q;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Directed self-checking bench for hi_lo_muldiv_unit.
module tb_hi_lo_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vector_t;

    hi_lo_muldiv_unit dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .op                 (op),
        .operand_a          (operand_a),
        .operand_b          (operand_b),
        .abort              (abort),
        .busy               (busy),
        .done               (done),
        .HI_LO_write_enable (we),
        .HI_write_data      (hi),
        .LO_write_data      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; start is sampled on the next posedge (T0). Returns at the negedge after T0.
    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts edges until done is seen at a negedge; -1 if the budget expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Counts write strobes over n cycles.
    task automatic count_strobes(input int n, output int strobes);
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || we) strobes++;
        end
    endtask

    vector_t vecs[13];

    initial begin
        int lat;
        int strobes;

        vecs[0]  = '{"multu_max",     MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg3x5",   MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"mult_min_min",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{"mult_7xneg1",   MD_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[4]  = '{"mult_0xneg5",   MD_MULT,  32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};
        vecs[5]  = '{"multu_2p32",    MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[6]  = '{"div_neg7by2",   MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[7]  = '{"divu_7by2",     MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[8]  = '{"div_by_zero",   MD_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[9]  = '{"div_overflow",  MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{"div_7byneg2",   MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[11] = '{"divu_big",      MD_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[12] = '{"divu_by_zero",  MD_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        op        = MD_MULT;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);

        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset we",   64'(we),   64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        reset_n = 1'b1;
        step_cycles(2);

        // Table-driven vectors: latency, strobe width and results.
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("%s busy", vecs[i].name), 64'(busy), 64'd1);
            wait_done(lat);
            check($sformatf("%s latency", vecs[i].name), 64'(lat), 64'(MD_LATENCY));
            check($sformatf("%s we", vecs[i].name), 64'(we), 64'd1);
            check($sformatf("%s hi", vecs[i].name), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("%s lo", vecs[i].name), 64'(lo), 64'(vecs[i].exp_lo));
            step_cycles(1);
            check($sformatf("%s done width", vecs[i].name), 64'({done, we}), 64'd0);
        end

        // Start while busy is ignored and does not re-latch operands.
        issue(MD_MULTU, 32'd3, 32'd4);
        step_cycles(4);
        op        = MD_DIV;
        operand_a = 32'd9;
        operand_b = 32'd9;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("ignored start busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("ignored start latency", 64'(lat + 5), 64'(MD_LATENCY));
        check("ignored start hi", 64'(hi), 64'd0);
        check("ignored start lo", 64'(lo), 64'd12);
        step_cycles(1);

        // Back-to-back: a new op issued in the DONE cycle is accepted.
        issue(MD_DIV, 32'd100, 32'd7);
        wait_done(lat);
        check("b2b first latency", 64'(lat), 64'(MD_LATENCY));
        check("b2b first hi", 64'(hi), 64'd2);
        check("b2b first lo", 64'(lo), 64'd14);
        issue(MD_DIVU, 32'd7, 32'd2);
        check("b2b second busy", 64'(busy), 64'd1);
        check("b2b second done low", 64'(done), 64'd0);
        check("b2b hold hi", 64'(hi), 64'd2);
        check("b2b hold lo", 64'(lo), 64'd14);
        wait_done(lat);
        check("b2b second latency", 64'(lat), 64'(MD_LATENCY));
        check("b2b second hi", 64'(hi), 64'd1);
        check("b2b second lo", 64'(lo), 64'd3);
        step_cycles(1);

        // Abort mid-RUN: no strobe, busy drops, HI/LO keep the previous result.
        issue(MD_MULTU, 32'd5, 32'd5);
        step_cycles(9);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        count_strobes(40, strobes);
        check("abort strobes", 64'(strobes), 64'd0);
        check("abort hi", 64'(hi), 64'd1);
        check("abort lo", 64'(lo), 64'd3);

        // Abort and start together in IDLE: abort wins.
        op        = MD_MULTU;
        operand_a = 32'd1;
        operand_b = 32'd1;
        start     = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort+start busy", 64'(busy), 64'd0);
        count_strobes(40, strobes);
        check("abort+start strobes", 64'(strobes), 64'd0);

        // Asynchronous reset mid-RUN clears outputs without a clock edge.
        issue(MD_MULTU, 32'd3, 32'd4);
        step_cycles(19);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        check("async reset hi",   64'(hi),   64'd0);
        check("async reset lo",   64'(lo),   64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step_cycles(1);
        issue(MD_MULTU, 32'd2, 32'd3);
        wait_done(lat);
        check("post reset latency", 64'(lat), 64'(MD_LATENCY));
        check("post reset hi", 64'(hi), 64'd0);
        check("post reset lo", 64'(lo), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
